// File: rtl/maxpool_pkg.sv
// Shared types and elaboration helpers for the max-pool window address generators.
package maxpool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int out_size(input int m, input int p, input int s);
    return (m - p) / s + 1;
  endfunction

  // Counter/selector widths never collapse to zero bits for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int sel_w(input int p);
    return cnt_w(p * p);
  endfunction

endpackage

// File: rtl/maxpool_window_addr_ch.sv
// One max-pool address channel: IDLE/RUN/DONE FSM, window counters and address adder.
// Optional abort input when MAXPOOL_FILL_ABORT_EN is defined.
module maxpool_window_addr_ch
  import maxpool_pkg::*;
#(
  parameter int MATRIX_SIZE = 16,
  parameter int ADD_SIZE    = 14,
  parameter int POOL_SIZE   = 2,
  parameter int STRIDE      = 2,
  parameter int SEL_W       = sel_w(POOL_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADD_SIZE-1:0] base_addr,
  input  logic                ready,
`ifdef MAXPOOL_FILL_ABORT_EN
  input  logic                abort,
`endif
  output logic [ADD_SIZE-1:0] add_out,
  output logic [SEL_W-1:0]    sel,
  output logic                valid,
  output logic                win_last,
  output logic                busy,
  output logic                done
);

  localparam int OUT_SIZE = out_size(MATRIX_SIZE, POOL_SIZE, STRIDE);
  localparam int OW       = cnt_w(OUT_SIZE);
  localparam int KW       = cnt_w(POOL_SIZE);

  ch_state_e           state_q, state_d;
  logic [ADD_SIZE-1:0] base_q, base_d;
  logic [OW-1:0]       out_row_q, out_row_d, out_col_q, out_col_d;
  logic [KW-1:0]       k_row_q, k_row_d, k_col_q, k_col_d;

  logic kc_last, kr_last, oc_last, or_last, final_elem, xfer, abort_req;
  logic [ADD_SIZE-1:0] row_a, col_a, addr;
  logic [SEL_W-1:0]    sel_raw;

`ifdef MAXPOOL_FILL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign kc_last    = (k_col_q   == KW'(POOL_SIZE - 1));
  assign kr_last    = (k_row_q   == KW'(POOL_SIZE - 1));
  assign oc_last    = (out_col_q == OW'(OUT_SIZE - 1));
  assign or_last    = (out_row_q == OW'(OUT_SIZE - 1));
  assign final_elem = kc_last && kr_last && oc_last && or_last;
  // Abort wins over a transfer in the same cycle, so it also blocks counting.
  assign xfer       = (state_q == ST_RUN) && ready && !abort_req;

  // Address arithmetic is deliberately modulo 2^ADD_SIZE.
  assign row_a   = ADD_SIZE'(out_row_q) * ADD_SIZE'(STRIDE) + ADD_SIZE'(k_row_q);
  assign col_a   = ADD_SIZE'(out_col_q) * ADD_SIZE'(STRIDE) + ADD_SIZE'(k_col_q);
  assign addr    = base_q + row_a * ADD_SIZE'(MATRIX_SIZE) + col_a;
  assign sel_raw = SEL_W'(k_row_q) * SEL_W'(POOL_SIZE) + SEL_W'(k_col_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      k_row_q   <= '0;
      k_col_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      k_row_q   <= k_row_d;
      k_col_q   <= k_col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (abort_req)               state_d = ST_IDLE;
        else if (xfer && final_elem) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // k_col runs fastest, then k_row, out_col, out_row.
  always_comb begin
    base_d    = base_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    k_row_d   = k_row_q;
    k_col_d   = k_col_q;
    if (state_q == ST_IDLE && start) begin
      base_d    = base_addr;
      out_row_d = '0;
      out_col_d = '0;
      k_row_d   = '0;
      k_col_d   = '0;
    end else if (xfer) begin
      if (!kc_last) k_col_d = k_col_q + 1'b1;
      else begin
        k_col_d = '0;
        if (!kr_last) k_row_d = k_row_q + 1'b1;
        else begin
          k_row_d = '0;
          if (!oc_last) out_col_d = out_col_q + 1'b1;
          else begin
            out_col_d = '0;
            out_row_d = or_last ? '0 : out_row_q + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    valid    = (state_q == ST_RUN);
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    win_last = valid && kr_last && kc_last;
    add_out  = valid ? addr : '0;
    sel      = valid ? sel_raw : '0;
  end

endmodule

// File: rtl/maxpool_window_addr_array.sv
// Array of independent max-pool window address channels over packed per-channel buses.
// Define MAXPOOL_FILL_ABORT_EN to add a per-channel abort input.
module maxpool_window_addr_array
  import maxpool_pkg::*;
#(
  parameter int MATRIX_SIZE = 16,
  parameter int ADD_SIZE    = 14,
  parameter int ARRAY_SIZE  = 9,
  parameter int POOL_SIZE   = 2,
  parameter int STRIDE      = 2,
  localparam int SEL_W      = sel_w(POOL_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ARRAY_SIZE-1:0]          start,
  input  logic [ARRAY_SIZE*ADD_SIZE-1:0] base_addr,
  input  logic [ARRAY_SIZE-1:0]          ready,
`ifdef MAXPOOL_FILL_ABORT_EN
  input  logic [ARRAY_SIZE-1:0]          abort,
`endif
  output logic [ARRAY_SIZE*ADD_SIZE-1:0] add_out,
  output logic [ARRAY_SIZE*SEL_W-1:0]    sel,
  output logic [ARRAY_SIZE-1:0]          valid,
  output logic [ARRAY_SIZE-1:0]          win_last,
  output logic [ARRAY_SIZE-1:0]          busy,
  output logic [ARRAY_SIZE-1:0]          done
);

  if (POOL_SIZE < 1 || STRIDE < 1 || POOL_SIZE > MATRIX_SIZE) begin : g_bad_size
    $error("maxpool_window_addr_array: invalid POOL_SIZE/STRIDE");
  end
  if ((MATRIX_SIZE - POOL_SIZE) % STRIDE != 0) begin : g_bad_stride
    $error("maxpool_window_addr_array: (MATRIX_SIZE-POOL_SIZE) not divisible by STRIDE");
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_ch
    maxpool_window_addr_ch #(
      .MATRIX_SIZE(MATRIX_SIZE),
      .ADD_SIZE   (ADD_SIZE),
      .POOL_SIZE  (POOL_SIZE),
      .STRIDE     (STRIDE),
      .SEL_W      (SEL_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .start    (start[i]),
      .base_addr(base_addr[i*ADD_SIZE +: ADD_SIZE]),
      .ready    (ready[i]),
`ifdef MAXPOOL_FILL_ABORT_EN
      .abort    (abort[i]),
`endif
      .add_out  (add_out[i*ADD_SIZE +: ADD_SIZE]),
      .sel      (sel[i*SEL_W +: SEL_W]),
      .valid    (valid[i]),
      .win_last (win_last[i]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_maxpool_window_addr_array.sv
// Scoreboard bench: default 16/2/2 array plus a 5/3/1 overlapping-window instance.
module tb_maxpool_window_addr_array;

  localparam int AS = 9, AW = 14, SW = 2, OSW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [AS-1:0]    start, ready, valid, win_last, busy, done;
  logic [AS*AW-1:0] base_addr, add_out;
  logic [AS*SW-1:0] sel;
  logic             ov_start, ov_ready, ov_valid, ov_wl, ov_busy, ov_done;
  logic [AW-1:0]    ov_base, ov_add;
  logic [OSW-1:0]   ov_sel;
`ifdef MAXPOOL_FILL_ABORT_EN
  logic [AS-1:0]    abort;
  logic             ov_abort;
`endif

  maxpool_window_addr_array dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .ready(ready),
`ifdef MAXPOOL_FILL_ABORT_EN
    .abort(abort),
`endif
    .add_out(add_out), .sel(sel), .valid(valid), .win_last(win_last), .busy(busy), .done(done)
  );

  maxpool_window_addr_array #(.MATRIX_SIZE(5), .ADD_SIZE(AW), .ARRAY_SIZE(1), .POOL_SIZE(3), .STRIDE(1)) dut_ov (
    .clk(clk), .reset(reset), .start(ov_start), .base_addr(ov_base), .ready(ov_ready),
`ifdef MAXPOOL_FILL_ABORT_EN
    .abort(ov_abort),
`endif
    .add_out(ov_add), .sel(ov_sel), .valid(ov_valid), .win_last(ov_wl), .busy(ov_busy), .done(ov_done)
  );

  typedef struct packed {logic [AW-1:0] a; logic [OSW-1:0] s; logic wl;} exp_t;
  typedef struct {int cyc; int a; int s;} spot_t;

  exp_t  q0[$], q5[$], qov[$];
  spot_t spots[$];
  int    nvec = 0, nerr = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_spot(input int c, input int a, input int s);
    spot_t sp;
    sp.cyc = c; sp.a = a; sp.s = s;
    spots.push_back(sp);
  endtask

  // Reference walk: nested loops over the window grid, first `limit` elements.
  task automatic push_win(input int which, input int base, input int m, input int p,
                          input int s, input int limit);
    int os, n;
    exp_t e;
    os = (m - p) / s + 1;
    n  = 0;
    for (int orr = 0; orr < os; orr++)
      for (int oc = 0; oc < os; oc++)
        for (int kr = 0; kr < p; kr++)
          for (int kc = 0; kc < p; kc++) begin
            if (n < limit) begin
              e.a  = AW'(base + (orr * s + kr) * m + oc * s + kc);
              e.s  = OSW'(kr * p + kc);
              e.wl = (kr == p - 1) && (kc == p - 1);
              case (which)
                0:       q0.push_back(e);
                5:       q5.push_back(e);
                default: qov.push_back(e);
              endcase
            end
            n++;
          end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return q0.size();
      5:       return q5.size();
      default: return qov.size();
    endcase
  endfunction

  task automatic pop_chk(input int which, input logic [AW-1:0] a, input logic [OSW-1:0] s,
                         input logic wl);
    exp_t e;
    if (qsize(which) == 0) begin
      nvec++;
      nerr++;
      $display("FAIL ch%0d_xfer: got transfer addr %0d, want none", which, a);
      return;
    end
    case (which)
      0:       e = q0.pop_front();
      5:       e = q5.pop_front();
      default: e = qov.pop_front();
    endcase
    cmp($sformatf("ch%0d_addr", which), int'(a), int'(e.a));
    cmp($sformatf("ch%0d_sel", which), int'(s), int'(e.s));
    cmp($sformatf("ch%0d_win_last", which), int'(wl), int'(e.wl));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (valid[0] && ready[0]) pop_chk(0, add_out[AW-1:0], OSW'(sel[SW-1:0]), win_last[0]);
      if (valid[5] && ready[5]) pop_chk(5, add_out[5*AW +: AW], OSW'(sel[5*SW +: SW]), win_last[5]);
      if (ov_valid && ov_ready) pop_chk(2, ov_add, ov_sel, ov_wl);
    end
  end

  // Drive one channel (0 = dut ch0, other = overlap dut) through a full run.
  task automatic run(input int which, input int base, input int exp_cyc, input int stall_at,
                     input int stall_len, input int restart_at);
    logic v, d, b;
    int   a, s, cyc, found;
    found = 0;
    if (which == 0) begin base_addr[AW-1:0] = AW'(base); start[0] = 1'b1; end
    else begin ov_base = AW'(base); ov_start = 1'b1; end
    tick();
    start[0] = 1'b0; ov_start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      if (which == 0) begin
        ready[0] = !(cyc >= stall_at && cyc < stall_at + stall_len);
        start[0] = (cyc == restart_at);
      end else begin
        ov_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
        ov_start = (cyc == restart_at);
      end
      @(negedge clk);
      if (which == 0) begin
        v = valid[0]; a = int'(add_out[AW-1:0]); s = int'(sel[SW-1:0]); d = done[0]; b = busy[0];
      end else begin
        v = ov_valid; a = int'(ov_add); s = int'(ov_sel); d = ov_done; b = ov_busy;
      end
      foreach (spots[i])
        if (spots[i].cyc == cyc) begin
          cmp($sformatf("spot_addr_c%0d", cyc), a, spots[i].a);
          cmp($sformatf("spot_sel_c%0d", cyc), s, spots[i].s);
        end
      if (d) begin found = 1; break; end
      tick();
      cyc++;
    end
    spots.delete();
    start[0] = 1'b0; ov_start = 1'b0; ready[0] = 1'b1; ov_ready = 1'b1;
    cmp("done_seen", found, 1);
    cmp("done_cycle", cyc, exp_cyc);
    cmp("busy_in_done", int'(b), 1);
    cmp("valid_in_done", int'(v), 0);
    cmp("queue_drained", qsize(which), 0);
    tick();
    @(negedge clk);
    if (which == 0) begin d = done[0]; b = busy[0]; end
    else begin d = ov_done; b = ov_busy; end
    cmp("busy_after_done", int'(b), 0);
    cmp("done_one_cycle", int'(d), 0);
    tick();
  endtask

  initial begin
    int d0, d5, seen;
    start = '0; ready = '1; base_addr = '0;
    ov_start = 1'b0; ov_ready = 1'b1; ov_base = '0;
`ifdef MAXPOOL_FILL_ABORT_EN
    abort = '0; ov_abort = 1'b0;
`endif
    #2 reset = 1'b1;
    #1;
    cmp("rst_add_out", int'(|add_out), 0);
    cmp("rst_sel", int'(|sel), 0);
    cmp("rst_valid", int'(|valid), 0);
    cmp("rst_win_last", int'(|win_last), 0);
    cmp("rst_busy", int'(|busy), 0);
    cmp("rst_done", int'(|done), 0);
    cmp("rst_ov", int'(|{ov_add, ov_sel, ov_valid, ov_wl, ov_busy, ov_done}), 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Basic walk, base 100.
    push_win(0, 100, 16, 2, 2, 256);
    add_spot(1, 100, 0); add_spot(2, 101, 1); add_spot(3, 116, 2); add_spot(4, 117, 3);
    add_spot(5, 102, 0); add_spot(256, 355, 3);
    run(0, 100, 257, 0, 0, 0);

    // Backpressure: stall on sel=2 for three cycles.
    push_win(0, 100, 16, 2, 2, 256);
    add_spot(3, 116, 2); add_spot(4, 116, 2); add_spot(5, 116, 2); add_spot(6, 116, 2);
    add_spot(7, 117, 3);
    run(0, 100, 260, 3, 3, 0);

    // Overlapping 3x3 windows, stride 1, on 5x5.
    push_win(2, 0, 5, 3, 1, 81);
    add_spot(1, 0, 0); add_spot(2, 1, 1); add_spot(3, 2, 2); add_spot(4, 5, 3);
    add_spot(5, 6, 4); add_spot(6, 7, 5); add_spot(7, 10, 6); add_spot(8, 11, 7);
    add_spot(9, 12, 8); add_spot(10, 1, 0); add_spot(81, 24, 8);
    run(2, 0, 82, 0, 0, 0);

    // Address wrap plus a start re-pulse mid-run that must be ignored.
    push_win(0, 16380, 16, 2, 2, 256);
    add_spot(1, 16380, 0); add_spot(4, 13, 3);
    run(0, 16380, 257, 0, 0, 50);

    // Reset mid-run: outputs drop at once, no done afterwards.
    push_win(0, 0, 16, 2, 2, 20);
    base_addr[AW-1:0] = '0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    #1;
    cmp("midrst_valid", int'(valid[0]), 0);
    cmp("midrst_busy", int'(busy[0]), 0);
    cmp("midrst_add_out", int'(add_out[AW-1:0]), 0);
    cmp("midrst_win_last", int'(win_last[0]), 0);
    cmp("midrst_done", int'(done[0]), 0);
    cmp("midrst_xfers", qsize(0), 0);
    q0.delete();
    repeat (2) tick();
    reset = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done[0] || valid[0]) seen = 1;
    end
    cmp("midrst_no_done", seen, 0);
    tick();

    // Channels 0 and 5 started four cycles apart.
    push_win(0, 500, 16, 2, 2, 256);
    push_win(5, 1000, 16, 2, 2, 256);
    base_addr[AW-1:0] = AW'(500); base_addr[5*AW +: AW] = AW'(1000);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    d0 = 0; d5 = 0;
    for (int c = 1; c < 400; c++) begin
      start[5] = (c == 4);
      @(negedge clk);
      if (done[0] && d0 == 0) d0 = c;
      if (done[5] && d5 == 0) d5 = c;
      if (d0 != 0 && d5 != 0) break;
      tick();
    end
    start[5] = 1'b0;
    cmp("indep_done0", d0, 257);
    cmp("indep_done5", d5, 261);
    cmp("indep_q0", qsize(0), 0);
    cmp("indep_q5", qsize(5), 0);
    repeat (2) tick();

`ifdef MAXPOOL_FILL_ABORT_EN
    // Abort with the 11th element presented; it still shows on the bus that cycle.
    push_win(0, 200, 16, 2, 2, 11);
    base_addr[AW-1:0] = AW'(200); start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (10) tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    @(negedge clk);
    cmp("abort_valid", int'(valid[0]), 0);
    cmp("abort_busy", int'(busy[0]), 0);
    cmp("abort_xfers", qsize(0), 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[0]) seen = 1;
    end
    cmp("abort_no_done", seen, 0);
    tick();
    push_win(0, 200, 16, 2, 2, 256);
    add_spot(1, 200, 0);
    run(0, 200, 257, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
